// File: rtl/latency_memory.sv
// latency_memory: word-organised 16-bit memory with a fixed, programmable
// response latency. It serves a read/write request handshake: the request
// is latched at acceptance, counted down, committed, and acknowledged with
// a one-cycle resp pulse.
module latency_memory #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  wmask,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    output logic        resp,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [15:0] req_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    op_wr_q, op_wr_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [1:0]              mask_q, mask_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [15:0]             rdata_q, rdata_d;
    logic [15:0]             count_q, count_d;

    // Storage is deliberately not reset; contents survive rst_n.
    logic [15:0]             mem_q [0:DEPTH-1];

    // Operands of the access performed at the edge that enters DONE.
    logic                    commit;
    logic                    c_wr;
    logic [ADDR_WIDTH-1:0]   c_idx;
    logic [1:0]              c_mask;
    logic [15:0]             c_data;

    // Byte-address bit 0 and bits above the word index do not select storage.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[15:ADDR_WIDTH+1], address[0]};

    // Next-state, latching and commit decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        count_d = count_q;
        commit  = 1'b0;
        c_wr    = op_wr_q;
        c_idx   = idx_q;
        c_mask  = mask_q;
        c_data  = wdata_q;

        case (state_q)
            IDLE: begin
                if (read || write) begin
                    // A simultaneous read and write is handled as a write.
                    op_wr_d = write;
                    idx_d   = address[ADDR_WIDTH:1];
                    mask_d  = wmask;
                    wdata_d = wdata;
                    cnt_d   = LAT_M1;
                    if (LATENCY == 1) begin
                        // Single-cycle latency commits at the accept edge, so
                        // the live inputs are used instead of the latches.
                        state_d = DONE;
                        commit  = 1'b1;
                        c_wr    = write;
                        c_idx   = address[ADDR_WIDTH:1];
                        c_mask  = wmask;
                        c_data  = wdata;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = count_q + 16'd1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // No access may land while reset is held.
        commit = commit && rst_n;

        if (commit && !c_wr) begin
            rdata_d = mem_q[c_idx];
        end
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            count_q <= count_d;
        end
    end

    // Byte-masked write into the storage array at the commit edge.
    always_ff @(posedge clk) begin
        if (commit && c_wr) begin
            if (c_mask[0]) begin
                mem_q[c_idx][7:0] <= c_data[7:0];
            end
            if (c_mask[1]) begin
                mem_q[c_idx][15:8] <= c_data[15:8];
            end
        end
    end

    assign resp      = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rdata     = rdata_q;
    assign req_count = count_q;

endmodule

// File: tb/tb_latency_memory.sv
// Bench for latency_memory: directed vector table plus hand-written
// sequences for back-to-back requests, reset mid-write and LATENCY=1.
module tb_latency_memory;

    localparam int unsigned LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        read, write;
    logic [1:0]  wmask;
    logic [15:0] address, wdata;
    logic        resp, busy;
    logic [15:0] rdata, req_count;

    logic        r1_read, r1_write;
    logic [1:0]  r1_wmask;
    logic [15:0] r1_address, r1_wdata;
    logic        resp1, busy1;
    logic [15:0] rdata1, count1;

    int checks = 0;
    int errors = 0;

    latency_memory #(.ADDR_WIDTH(8), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .wmask(wmask),
        .address(address), .wdata(wdata), .resp(resp), .rdata(rdata),
        .busy(busy), .req_count(req_count)
    );

    latency_memory #(.ADDR_WIDTH(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .read(r1_read), .write(r1_write), .wmask(r1_wmask),
        .address(r1_address), .wdata(r1_wdata), .resp(resp1), .rdata(rdata1),
        .busy(busy1), .req_count(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  mask;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // One full handshake on the LATENCY=4 instance; inputs are scrambled
    // after acceptance to show they are latched.
    task automatic do_req(input logic rd, input logic wr, input logic [1:0] m,
                          input logic [15:0] a, input logic [15:0] d, input string tag);
        int  n;
        logic seen;
        @(negedge clk);
        read = rd; write = wr; wmask = m; address = a; wdata = d;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
                address = 16'hFFFE; wdata = 16'hDEAD; wmask = 2'b11;
            end
            if (resp) seen = 1'b1;
        end
        chk({tag, "_latency"}, n, LAT);
        read = 1'b0; write = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_resp_width"}, {31'd0, resp}, 32'd0);
    endtask

    vec_t vecs[14];
    int   exp_cnt;

    initial begin
        int   t[3];
        int   k, e, wide;
        logic prev, seen;
        int   base;

        vecs[0]  = '{1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[2]  = '{1'b0, 1'b1, 2'b11, 16'h0020, 16'h1234, 16'hBEEF};
        vecs[3]  = '{1'b0, 1'b1, 2'b01, 16'h0020, 16'hABCD, 16'hBEEF};
        vecs[4]  = '{1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'h12CD};
        vecs[5]  = '{1'b0, 1'b1, 2'b10, 16'h0020, 16'hABCD, 16'h12CD};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'hABCD};
        vecs[7]  = '{1'b0, 1'b1, 2'b00, 16'h0020, 16'h9999, 16'hABCD};
        vecs[8]  = '{1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'hABCD};
        vecs[9]  = '{1'b0, 1'b1, 2'b11, 16'h0202, 16'h7777, 16'hABCD};
        vecs[10] = '{1'b1, 1'b0, 2'b00, 16'h0002, 16'h0000, 16'h7777};
        vecs[11] = '{1'b1, 1'b1, 2'b11, 16'h0002, 16'h4242, 16'h7777};
        vecs[12] = '{1'b1, 1'b0, 2'b00, 16'h0003, 16'h0000, 16'h4242};
        vecs[13] = '{1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF};

        rst_n = 1'b1;
        read = 0; write = 0; wmask = 0; address = 0; wdata = 0;
        r1_read = 0; r1_write = 0; r1_wmask = 0; r1_address = 0; r1_wdata = 0;

        // Asynchronous reset: outputs settle with no clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_resp", {31'd0, resp}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_count", {16'd0, req_count}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // LATENCY=1: resp in the cycle right after the accept edge.
        @(negedge clk);
        r1_write = 1'b1; r1_wmask = 2'b11; r1_address = 16'h0004; r1_wdata = 16'h1111;
        @(posedge clk); #1;
        chk("l1_wr_resp", {31'd0, resp1}, 32'd1);
        chk("l1_wr_busy", {31'd0, busy1}, 32'd1);
        r1_write = 1'b0;
        @(posedge clk); #1;
        chk("l1_wr_resp_low", {31'd0, resp1}, 32'd0);
        chk("l1_count1", {16'd0, count1}, 32'd1);
        @(negedge clk);
        r1_read = 1'b1;
        @(posedge clk); #1;
        chk("l1_rd_resp", {31'd0, resp1}, 32'd1);
        chk("l1_rdata", {16'd0, rdata1}, 32'h1111);
        r1_read = 1'b0;
        @(posedge clk); #1;
        chk("l1_count2", {16'd0, count1}, 32'd2);

        // Table-driven requests on the LATENCY=4 instance.
        exp_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].mask, vecs[i].addr, vecs[i].data,
                   $sformatf("vec%0d", i));
            exp_cnt++;
            chk($sformatf("vec%0d_rdata", i), {16'd0, rdata}, {16'd0, vecs[i].exp_rdata});
            chk($sformatf("vec%0d_count", i), {16'd0, req_count}, exp_cnt);
        end

        // Back-to-back: read held high continuously.
        base = exp_cnt;
        @(negedge clk);
        read = 1'b1; address = 16'h0010;
        k = 0; e = 0; wide = 0; prev = 1'b0;
        while (k < 3 && e < 40) begin
            @(posedge clk); #1;
            e++;
            if (resp && prev) wide++;
            if (resp) begin
                t[k] = e;
                k++;
            end
            prev = resp;
        end
        read = 1'b0;
        chk("b2b_resps", k, 3);
        chk("b2b_first", t[0], LAT);
        chk("b2b_gap1", t[1] - t[0], LAT + 1);
        chk("b2b_gap2", t[2] - t[1], LAT + 1);
        @(posedge clk); #1;
        if (resp && prev) wide++;
        chk("b2b_width", wide, 0);
        exp_cnt = base + 3;
        chk("b2b_count", {16'd0, req_count}, exp_cnt);
        chk("b2b_rdata", {16'd0, rdata}, 32'h0000BEEF);

        // Reset during a write: the write is dropped and no resp appears.
        do_req(1'b0, 1'b1, 2'b11, 16'h0030, 16'h0000, "pre30");
        @(negedge clk);
        write = 1'b1; wmask = 2'b11; address = 16'h0030; wdata = 16'h5555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_resp", {31'd0, resp}, 32'd0);
        chk("abort_rdata", {16'd0, rdata}, 32'd0);
        chk("abort_count", {16'd0, req_count}, 32'd0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp) seen = 1'b1;
        end
        write = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        chk("abort_no_resp", {31'd0, seen}, 32'd0);
        do_req(1'b1, 1'b0, 2'b00, 16'h0030, 16'h0000, "post30");
        chk("abort_readback", {16'd0, rdata}, 32'd0);
        chk("abort_count_after", {16'd0, req_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
